pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile.sv | 147 ++++++++++++++
 tb/tb_pipe_regfile.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
//   Multi-port register file with an optional hardwired-zero register 0, a
//   write-to-read bypass on the combinational read ports, a registered debug
//   read port, and a hardware "clear all" sweep that zeroes one register per
//   cycle.
//
// Ports
//   clk      : sole clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset (clears every register)
//   startin  : one-cycle pulse that starts a clear sweep (ignored while busy)
//   busy     : high while the clear sweep runs (exactly NREGS cycles)
//   we       : write enable (ignored while busy)
//   waddr    : write address
//   wdata    : write data
//   raddr    : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    : packed combinational read data, port i at [i*DATA_W +: DATA_W]
//   regNo    : debug read address
//   val      : debug read value, registered (one-cycle latency, no bypass)
// -----------------------------------------------------------------------------
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startin,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0]     regNo,
    output logic [DATA_W-1:0]     val
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    // Register 0 is hardwired to zero when ZERO_REG is set: reads mask it and
    // writes to it are dropped.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
        return is_zero_reg(addr) ? '0 : regs[addr];
    endfunction

    // A user write only happens while idle; the sweep owns the write port
    // while it runs.
    assign wr_en = (state == IDLE) && we && !is_zero_reg(waddr);
    assign busy  = (state == CLEAR);

    // ---------------------------------------------------------------- FSM ---
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (startin) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                // startin is deliberately not looked at here: no restart.
                cnt_nx = cnt + 1'b1;
                if (cnt == ADDR_W'(NREGS - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // ------------------------------------------------------ register array ---
    // NOTE: the storage array is reset on purpose: reset must leave every
    // register reading 0, so this array is built from resettable flops rather
    // than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------- read ports -----
    // A port addressing the register being written this cycle sees the new
    // data immediately (bypass). wr_en already excludes the hardwired zero
    // register and the sweep.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (wr_en && (raddr[i*ADDR_W +: ADDR_W] == waddr)) begin
                rdata[i*DATA_W +: DATA_W] = wdata;
            end else begin
                rdata[i*DATA_W +: DATA_W] = read_reg(raddr[i*ADDR_W +: ADDR_W]);
            end
        end
    end

    // Debug port: samples the stored value, so a same-cycle write shows up
    // one edge later than on rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
        end else begin
            val <= read_reg(regNo);
        end
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// -----------------------------------------------------------------------------
// tb_pipe_regfile
//   Self-checking bench for pipe_regfile. A ZERO_REG=1 instance is driven by
//   directed and random stimulus and compared every cycle against a
//   behavioural model of the register file; a ZERO_REG=0 instance checks that
//   register 0 is writable in that configuration.
// -----------------------------------------------------------------------------
module tb_pipe_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          startin, we;
    logic [AW-1:0] waddr, regNo;
    logic [DW-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic          busy;
    logic [DW-1:0] val;

    // ZERO_REG=0 instance
    logic            we_nz;
    logic [AW-1:0]   waddr_nz, regno_nz;
    logic [DW-1:0]   wdata_nz, val_nz;
    logic [2*AW-1:0] raddr_nz;
    logic [2*DW-1:0] rdata_nz;
    logic            busy_nz;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [DW-1:0] m_regs [NR];
    bit            m_busy;
    int            m_pos;   // next register the sweep will clear
    logic [DW-1:0] m_val;

    always #5 clk = ~clk;

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .startin(startin), .busy(busy), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
        .regNo(regNo), .val(val)
    );

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .startin(1'b0), .busy(busy_nz), .we(we_nz),
        .waddr(waddr_nz), .wdata(wdata_nz), .raddr(raddr_nz), .rdata(rdata_nz),
        .regNo(regno_nz), .val(val_nz)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_busy && we && a == waddr && a != 0) return wdata;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = 0;
        m_pos  = 0;
        m_val  = '0;
    endtask

    // Apply the effect of one rising edge to the model using current inputs.
    task automatic model_edge();
        logic [DW-1:0] old_val;
        old_val = m_regs[regNo];
        if (!m_busy) begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (startin) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end else begin
            m_regs[m_pos] = '0;
            m_pos++;
            if (m_pos == NR) m_busy = 0;
        end
        m_val = old_val;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"},   {31'b0, busy}, {31'b0, m_busy});
        check({tag, ".val"},    val, m_val);
        check({tag, ".rdata0"}, rdata[DW-1:0],  exp_rd(raddr[AW-1:0]));
        check({tag, ".rdata1"}, rdata[2*DW-1:DW], exp_rd(raddr[2*AW-1:AW]));
    endtask

    // One clock: update model, pass the edge, sample 1 time unit later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_all_zero(input string tag);
        we = 0;
        for (int a = 0; a < NR; a++) begin
            raddr[AW-1:0] = AW'(a);
            #1;
            check($sformatf("%s.reg%0d", tag, a), rdata[DW-1:0], '0);
        end
    endtask

    task automatic fill_regs(input int n);
        for (int a = 1; a <= n; a++) begin
            we    = 1;
            waddr = AW'(a);
            wdata = $urandom | 32'h1;
            tick("fill");
        end
        we = 0;
    endtask

    initial begin
        int cnt;
        rst = 1; startin = 0; we = 0; waddr = '0; wdata = '0; raddr = '0; regNo = '0;
        we_nz = 0; waddr_nz = '0; wdata_nz = '0; raddr_nz = '0; regno_nz = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 0;

        // Write reg5 and observe on rdata (immediately) and val (two edges).
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; regNo = 5; raddr = {AW'(0), AW'(5)};
        tick("wr5");
        we = 0;
        #1;
        check("rd5_after_edge", rdata[DW-1:0], 32'hDEADBEEF);
        check("val5_one_edge", val, 32'h0);
        tick("wr5b");
        check("val5_two_edges", val, 32'hDEADBEEF);

        // Bypass on both ports in the write cycle.
        we = 1; waddr = 7; wdata = 32'h12345678; raddr = {AW'(7), AW'(7)};
        #1;
        check("bypass_p0", rdata[DW-1:0], 32'h12345678);
        check("bypass_p1", rdata[2*DW-1:DW], 32'h12345678);
        tick("wr7");

        // Register 0: hardwired on dut, writable on dut_nz.
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = '0; regNo = 0;
        we_nz = 1; waddr_nz = 0; wdata_nz = 32'hFFFFFFFF; raddr_nz = '0; regno_nz = 0;
        #1;
        check("zr_bypass", rdata[DW-1:0], 32'h0);
        check("nz_bypass", rdata_nz[DW-1:0], 32'hFFFFFFFF);
        tick("wr0");
        we = 0; we_nz = 0;
        tick("wr0b");
        check("zr_rd0", rdata[DW-1:0], 32'h0);
        check("zr_val0", val, 32'h0);
        check("nz_rd0", rdata_nz[DW-1:0], 32'hFFFFFFFF);
        check("nz_val0", val_nz, 32'hFFFFFFFF);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            startin = ($urandom_range(0, 39) == 0);
            we      = $urandom_range(0, 1);
            waddr   = AW'($urandom);
            wdata   = $urandom;
            regNo   = AW'($urandom);
            raddr[AW-1:0]    = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom);
            raddr[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom);
            #1;
            check_all("rand_pre");
            tick("rand");
        end
        startin = 0; we = 0;
        cnt = 0;
        while (m_busy && cnt < 100) begin
            tick("drain");
            cnt++;
        end

        // Full sweep: busy exactly 32 cycles, writes during busy ignored.
        fill_regs(31);
        startin = 1;
        tick("start1");
        startin = 0;
        cnt = 0;
        while (busy && cnt < 100) begin
            we = 1; waddr = AW'($urandom_range(1, 31)); wdata = $urandom | 32'h1;
            cnt++;
            tick("sweep1");
        end
        check("sweep1_len", cnt, 32);
        check_all_zero("sweep1_zero");

        // Second startin mid-sweep must not restart it.
        fill_regs(12);
        startin = 1;
        tick("start2");
        startin = 0;
        cnt = 0;
        while (busy && cnt < 100) begin
            startin = (cnt == 10);
            cnt++;
            tick("sweep2");
        end
        startin = 0;
        check("sweep2_len", cnt, 32);
        check_all_zero("sweep2_zero");

        // Reset mid-sweep.
        fill_regs(31);
        regNo = 20;
        tick("preval");
        startin = 1;
        tick("start3");
        startin = 0;
        for (int i = 0; i < 10; i++) tick("sweep3");
        rst = 1;
        #1;
        model_reset();
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_val", val, 32'h0);
        rst = 0;
        check_all_zero("rst_zero");

        // Coincident startin+we after reset: write commits, then is cleared.
        startin = 1; we = 1; waddr = 9; wdata = 32'hAAAA5555; raddr = {AW'(9), AW'(9)}; regNo = 9;
        #1;
        check_all("coinc_pre");
        tick("coinc");
        check("coinc_busy", {31'b0, busy}, 32'h1);
        check("coinc_rd9", rdata[DW-1:0], 32'hAAAA5555);
        startin = 0; we = 0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick("sweep4");
        end
        check("sweep4_len", cnt, 32);
        check_all_zero("sweep4_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
